// File: rtl/alu_op_issue_if.sv
// Decode/issue bus: fetched instruction and regfile data in, registered ALU
// operands out, with a valid/ready handshake on each side.
interface alu_op_issue_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
);
  logic [DATA_WIDTH-1:0]     InstrD;
  logic [DATA_WIDTH-1:0]     PCD;
  logic [DATA_WIDTH-1:0]     RD1D;
  logic [DATA_WIDTH-1:0]     RD2D;
  logic                      InValid;
  logic                      InReady;
  logic                      Flush;
  logic [DATA_WIDTH-1:0]     SrcAE;
  logic [DATA_WIDTH-1:0]     SrcBE;
  logic [ALU_CTRL_WIDTH-1:0] ALUControlE;
  logic [DATA_WIDTH-1:0]     PCE;
  logic                      IllegalE;
  logic                      OutValid;
  logic                      OutReady;
  logic [CNT_WIDTH-1:0]      IssueCount;

  // Upstream/downstream environment side.
  modport master (
    output InstrD, PCD, RD1D, RD2D, InValid, Flush, OutReady,
    input  InReady, SrcAE, SrcBE, ALUControlE, PCE, IllegalE, OutValid, IssueCount
  );

  // Issue stage side.
  modport slave (
    input  InstrD, PCD, RD1D, RD2D, InValid, Flush, OutReady,
    output InReady, SrcAE, SrcBE, ALUControlE, PCE, IllegalE, OutValid, IssueCount
  );
endinterface

// File: rtl/alu_op_issue.sv
// RV32I decode/issue stage: decodes the ALU op, selects and extends operands,
// and holds them in a single-entry valid/ready register feeding execute.
module alu_op_issue #(
  parameter int DATA_WIDTH     = 32,
  parameter int ALU_CTRL_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input logic         clk,
  input logic         rst,
  alu_op_issue_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_ADD    = ALU_CTRL_WIDTH'(0);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SUB    = ALU_CTRL_WIDTH'(1);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLL    = ALU_CTRL_WIDTH'(2);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLT    = ALU_CTRL_WIDTH'(3);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SLTU   = ALU_CTRL_WIDTH'(4);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_XOR    = ALU_CTRL_WIDTH'(5);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRL    = ALU_CTRL_WIDTH'(6);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_SRA    = ALU_CTRL_WIDTH'(7);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_OR     = ALU_CTRL_WIDTH'(8);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_AND    = ALU_CTRL_WIDTH'(9);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUIPC  = ALU_CTRL_WIDTH'(10);
  localparam logic [ALU_CTRL_WIDTH-1:0] ALU_LUI    = ALU_CTRL_WIDTH'(11);

  typedef struct packed {
    logic [ALU_CTRL_WIDTH-1:0] ctrl;
    logic [DATA_WIDTH-1:0]     src_a;
    logic [DATA_WIDTH-1:0]     src_b;
    logic                      ill;
  } dec_t;

  // Shared funct3 table for OP and OP-IMM; alt selects sub/sra.
  function automatic logic [ALU_CTRL_WIDTH-1:0] f3_code(input logic [2:0] f3, input logic alt);
    logic [ALU_CTRL_WIDTH-1:0] c;
    c = ALU_ADD;
    case (f3)
      3'b000: c = alt ? ALU_SUB : ALU_ADD;
      3'b001: c = ALU_SLL;
      3'b010: c = ALU_SLT;
      3'b011: c = ALU_SLTU;
      3'b100: c = ALU_XOR;
      3'b101: c = alt ? ALU_SRA : ALU_SRL;
      3'b110: c = ALU_OR;
      3'b111: c = ALU_AND;
      default: c = ALU_ADD;
    endcase
    return c;
  endfunction

  // Full decode of one instruction into ALU code, operands and illegal flag.
  function automatic dec_t decode(input logic [DATA_WIDTH-1:0] instr,
                                  input logic [DATA_WIDTH-1:0] rd1,
                                  input logic [DATA_WIDTH-1:0] rd2);
    dec_t              d;
    logic [6:0]        opc;
    logic [6:0]        f7;
    logic [2:0]        f3;
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = signed'(instr[31:20]);
    imm_s = signed'({instr[31:25], instr[11:7]});
    d.ctrl  = ALU_ADD;
    d.src_a = rd1;
    d.src_b = rd2;
    d.ill   = 1'b0;
    case (opc)
      OPC_OP: d.ctrl = f3_code(f3, f7[5]);
      OPC_OPIMM: begin
        d.src_b = DATA_WIDTH'(imm_i);
        case (f3)
          3'b000: d.ctrl = ALU_ADD;
          3'b001: begin
            if (f7 == 7'b0000000) d.ctrl = ALU_SLL;
            else                  d.ill  = 1'b1;
          end
          3'b101: begin
            if (f7 == 7'b0000000)      d.ctrl = ALU_SRL;
            else if (f7 == 7'b0100000) d.ctrl = ALU_SRA;
            else                       d.ill  = 1'b1;
          end
          default: d.ctrl = f3_code(f3, 1'b0);
        endcase
      end
      OPC_LUI: begin
        d.ctrl  = ALU_LUI;
        d.src_a = '0;
        d.src_b = DATA_WIDTH'(instr[31:12]);
      end
      OPC_AUIPC: begin
        d.ctrl  = ALU_LUIPC;
        d.src_a = '0;
        d.src_b = DATA_WIDTH'(instr[31:12]);
      end
      OPC_LOAD:   d.src_b = DATA_WIDTH'(imm_i);
      OPC_STORE:  d.src_b = DATA_WIDTH'(imm_s);
      OPC_BRANCH: d.ctrl  = ALU_SUB;
      default: begin
        // Unknown opcodes still issue so execute can raise the trap.
        d.src_a = '0;
        d.src_b = '0;
        d.ill   = 1'b1;
      end
    endcase
    return d;
  endfunction

  // ---- stage p0: decode and handshake from the incoming instruction ----
  dec_t dec_p0;
  logic in_ready_p0;
  logic accept_p0;

  logic                      vld_p1;
  logic [DATA_WIDTH-1:0]     src_a_p1;
  logic [DATA_WIDTH-1:0]     src_b_p1;
  logic [DATA_WIDTH-1:0]     pc_p1;
  logic [ALU_CTRL_WIDTH-1:0] ctrl_p1;
  logic                      ill_p1;
  logic [CNT_WIDTH-1:0]      issue_cnt;
  logic                      consume_p1;

  assign dec_p0      = decode(bus.InstrD, bus.RD1D, bus.RD2D);
  assign in_ready_p0 = ~bus.Flush & (~vld_p1 | bus.OutReady);
  assign accept_p0   = bus.InValid & in_ready_p0;
  assign consume_p1  = vld_p1 & bus.OutReady;

  // ---- stage p1: registered issue slot toward execute ----
  // Load on accept, drop valid on flush or plain consume, hold data otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      src_a_p1  <= '0;
      src_b_p1  <= '0;
      pc_p1     <= '0;
      ctrl_p1   <= ALU_ADD;
      ill_p1    <= 1'b0;
      issue_cnt <= '0;
    end else begin
      if (consume_p1) issue_cnt <= issue_cnt + CNT_WIDTH'(1);
      if (bus.Flush) begin
        vld_p1 <= 1'b0;
      end else if (accept_p0) begin
        vld_p1   <= 1'b1;
        src_a_p1 <= dec_p0.src_a;
        src_b_p1 <= dec_p0.src_b;
        pc_p1    <= bus.PCD;
        ctrl_p1  <= dec_p0.ctrl;
        ill_p1   <= dec_p0.ill;
      end else if (consume_p1) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign bus.InReady     = in_ready_p0;
  assign bus.OutValid    = vld_p1;
  assign bus.SrcAE       = src_a_p1;
  assign bus.SrcBE       = src_b_p1;
  assign bus.PCE         = pc_p1;
  assign bus.ALUControlE = ctrl_p1;
  assign bus.IllegalE    = ill_p1;
  assign bus.IssueCount  = issue_cnt;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench for alu_op_issue with a scoreboard of expected issued ops.
module tb_alu_op_issue;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int NW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_op_issue_if #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(AW), .CNT_WIDTH(NW)) bus ();

  alu_op_issue #(.DATA_WIDTH(DW), .ALU_CTRL_WIDTH(AW), .CNT_WIDTH(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] pc;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2);
    bus.InstrD = instr;
    bus.PCD    = pc;
    bus.RD1D   = rd1;
    bus.RD2D   = rd2;
  endtask

  task automatic push(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic ill);
    exp_t e;
    e.ctrl = ctrl; e.a = a; e.b = b; e.pc = pc; e.ill = ill;
    sb.push_back(e);
  endtask

  // Every output handshake is checked against the oldest expected op.
  always @(negedge clk) begin
    if (!rst && bus.OutValid === 1'b1 && bus.OutReady === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ctrl", 32'(bus.ALUControlE), 32'(e.ctrl));
        chk("sb_srca", bus.SrcAE, e.a);
        chk("sb_srcb", bus.SrcBE, e.b);
        chk("sb_pc",   bus.PCE,   e.pc);
        chk("sb_ill",  32'(bus.IllegalE), 32'(e.ill));
      end
    end
  end

  vec_t tbl [6];

  initial begin
    // store, branch, load, slt, srai, lui
    tbl[0] = '{32'hFE20AE23, 32'h00000100, 32'h0000AAAA, '{4'h0, 32'h00000100, 32'hFFFFFFFC, 32'h00000400, 1'b0}};
    tbl[1] = '{32'h00208063, 32'h00000009, 32'h00000004, '{4'h1, 32'h00000009, 32'h00000004, 32'h00000404, 1'b0}};
    tbl[2] = '{32'h00812083, 32'h00002000, 32'h00000077, '{4'h0, 32'h00002000, 32'h00000008, 32'h00000408, 1'b0}};
    tbl[3] = '{32'h0020A0B3, 32'hFFFFFFF0, 32'h00000003, '{4'h3, 32'hFFFFFFF0, 32'h00000003, 32'h0000040C, 1'b0}};
    tbl[4] = '{32'h4030D093, 32'h80000010, 32'h00000001, '{4'h7, 32'h80000010, 32'h00000403, 32'h00000410, 1'b0}};
    tbl[5] = '{32'h123450B7, 32'h00000055, 32'h00000066, '{4'hB, 32'h00000000, 32'h00012345, 32'h00000414, 1'b0}};

    drive(32'h0, 32'h0, 32'h0, 32'h0);
    bus.InValid  = 1'b0;
    bus.Flush    = 1'b0;
    bus.OutReady = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset while an op is stalled
    drive(32'h003140B3, 32'h10, 32'h7, 32'h9);
    bus.InValid = 1'b1;
    tick();
    bus.InValid = 1'b0;
    chk("stall_vld", 32'(bus.OutValid), 32'd1);
    chk("stall_ctrl", 32'(bus.ALUControlE), 32'd5);
    chk("stall_srca", bus.SrcAE, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_vld", 32'(bus.OutValid), 32'd0);
    chk("rst_ctrl", 32'(bus.ALUControlE), 32'd0);
    chk("rst_srca", bus.SrcAE, 32'd0);
    chk("rst_srcb", bus.SrcBE, 32'd0);
    chk("rst_pc", bus.PCE, 32'd0);
    chk("rst_ill", 32'(bus.IllegalE), 32'd0);
    chk("rst_cnt", 32'(bus.IssueCount), 32'd0);
    chk("rst_inready", 32'(bus.InReady), 32'd1);

    // sub with 1-cycle latency
    drive(32'h40208033, 32'h40, 32'd5, 32'd3);
    bus.InValid = 1'b1;
    push(4'h1, 32'd5, 32'd3, 32'h40, 1'b0);
    tick();
    bus.InValid = 1'b0;
    chk("sub_vld", 32'(bus.OutValid), 32'd1);
    chk("sub_ctrl", 32'(bus.ALUControlE), 32'd1);
    chk("sub_srca", bus.SrcAE, 32'd5);
    chk("sub_srcb", bus.SrcBE, 32'd3);
    chk("sub_ill", 32'(bus.IllegalE), 32'd0);
    bus.OutReady = 1'b1;
    tick();
    chk("sub_cnt", 32'(bus.IssueCount), 32'd1);
    chk("sub_drained", 32'(bus.OutValid), 32'd0);

    // addi -1 then auipc back-to-back
    drive(32'hFFF00093, 32'h104, 32'h11, 32'h0);
    bus.InValid = 1'b1;
    push(4'h0, 32'h11, 32'hFFFFFFFF, 32'h104, 1'b0);
    tick();
    chk("addi_ctrl", 32'(bus.ALUControlE), 32'd0);
    chk("addi_srcb", bus.SrcBE, 32'hFFFFFFFF);
    drive(32'h12345097, 32'h100, 32'h22, 32'h0);
    push(4'hA, 32'h0, 32'h00012345, 32'h100, 1'b0);
    #1;
    chk("b2b_inready", 32'(bus.InReady), 32'd1);
    tick();
    chk("auipc_vld", 32'(bus.OutValid), 32'd1);
    chk("auipc_ctrl", 32'(bus.ALUControlE), 32'hA);
    chk("auipc_srca", bus.SrcAE, 32'h0);
    chk("auipc_srcb", bus.SrcBE, 32'h00012345);
    chk("auipc_pc", bus.PCE, 32'h100);
    chk("b2b_cnt1", 32'(bus.IssueCount), 32'd2);
    bus.InValid = 1'b0;
    tick();
    chk("b2b_cnt2", 32'(bus.IssueCount), 32'd3);

    // backpressure: ori held for 3 cycles while sra waits
    bus.OutReady = 1'b0;
    drive(32'h0F016093, 32'h1F0, 32'hA5A50000, 32'h0);
    bus.InValid = 1'b1;
    push(4'h8, 32'hA5A50000, 32'h000000F0, 32'h1F0, 1'b0);
    tick();
    drive(32'h4030D0B3, 32'h200, 32'h80000000, 32'h4);
    #1;
    chk("bp_inready", 32'(bus.InReady), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_vld", 32'(bus.OutValid), 32'd1);
      chk("bp_ctrl", 32'(bus.ALUControlE), 32'd8);
      chk("bp_srca", bus.SrcAE, 32'hA5A50000);
      chk("bp_srcb", bus.SrcBE, 32'h000000F0);
      chk("bp_pc", bus.PCE, 32'h1F0);
    end
    bus.OutReady = 1'b1;
    #1;
    chk("bp_release_inready", 32'(bus.InReady), 32'd1);
    push(4'h7, 32'h80000000, 32'h4, 32'h200, 1'b0);
    tick();
    chk("bp_sra_ctrl", 32'(bus.ALUControlE), 32'd7);
    chk("bp_sra_srca", bus.SrcAE, 32'h80000000);
    chk("bp_cnt", 32'(bus.IssueCount), 32'd4);
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;

    // flush kills the held sra and blocks the incoming and
    drive(32'h0020F0B3, 32'h208, 32'h1, 32'h2);
    bus.InValid = 1'b1;
    bus.Flush   = 1'b1;
    #1;
    chk("flush_inready", 32'(bus.InReady), 32'd0);
    void'(sb.pop_back());
    tick();
    bus.Flush   = 1'b0;
    bus.InValid = 1'b0;
    chk("flush_vld", 32'(bus.OutValid), 32'd0);
    chk("flush_cnt", 32'(bus.IssueCount), 32'd4);
    tick();
    chk("flush_no_accept", 32'(bus.OutValid), 32'd0);

    // illegal encodings
    drive(32'h0000007F, 32'h300, 32'h1, 32'h2);
    bus.InValid = 1'b1;
    push(4'h0, 32'h0, 32'h0, 32'h300, 1'b1);
    tick();
    chk("ill_opc_flag", 32'(bus.IllegalE), 32'd1);
    chk("ill_opc_ctrl", 32'(bus.ALUControlE), 32'd0);
    chk("ill_opc_vld", 32'(bus.OutValid), 32'd1);
    bus.OutReady = 1'b1;
    drive(32'h40009093, 32'h304, 32'h55, 32'h0);
    push(4'h0, 32'h55, 32'h00000400, 32'h304, 1'b1);
    tick();
    chk("ill_slli_flag", 32'(bus.IllegalE), 32'd1);
    chk("ill_slli_ctrl", 32'(bus.ALUControlE), 32'd0);
    chk("ill_slli_vld", 32'(bus.OutValid), 32'd1);
    chk("ill_cnt", 32'(bus.IssueCount), 32'd5);
    // flush in the same cycle as a consume still counts the handshake
    bus.InValid = 1'b0;
    bus.Flush   = 1'b1;
    tick();
    bus.Flush = 1'b0;
    chk("flush_consume_vld", 32'(bus.OutValid), 32'd0);
    chk("flush_consume_cnt", 32'(bus.IssueCount), 32'd6);

    // remaining opcode classes, streamed
    foreach (tbl[k]) begin
      drive(tbl[k].instr, tbl[k].e.pc, tbl[k].rd1, tbl[k].rd2);
      bus.InValid = 1'b1;
      sb.push_back(tbl[k].e);
      tick();
    end
    bus.InValid = 1'b0;
    tick();
    chk("tbl_cnt", 32'(bus.IssueCount), 32'd12);

    // drive the counter to its maximum, then wrap
    for (int i = 0; i < 243; i++) begin
      logic [19:0] imm;
      imm = 20'($urandom);
      drive({imm, 5'd3, 7'b0110111}, 32'h1000 + 32'(i) * 4, 32'hDEAD, 32'hBEEF);
      bus.InValid = 1'b1;
      push(4'hB, 32'h0, {12'h0, imm}, 32'h1000 + 32'(i) * 4, 1'b0);
      tick();
    end
    bus.InValid = 1'b0;
    tick();
    chk("cnt_max", 32'(bus.IssueCount), 32'h000000FF);
    drive(32'h00208063, 32'h2000, 32'h3, 32'h3);
    bus.InValid = 1'b1;
    push(4'h1, 32'h3, 32'h3, 32'h2000, 1'b0);
    tick();
    bus.InValid = 1'b0;
    tick();
    chk("cnt_wrap", 32'(bus.IssueCount), 32'h00000000);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
